// File: rtl/dest_ip_tbl_pkg.sv
// dest_ip_tbl_pkg: shared constants and the FSM state encoding for the
// destination-IP table sequencer (dest_ip_tbl_ctrl).
package dest_ip_tbl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TBL_ADDR_W  = 5;
  localparam int unsigned TBL_DEPTH   = 2 ** TBL_ADDR_W;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned TO_CNT_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_CLR_ISSUE = 3'd3,
    ST_CLR_WAIT  = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/dest_ip_tbl_ctrl_if.sv
// dest_ip_tbl_ctrl_if: host (register block) access bus of the table sequencer.
//   master: register block side - drives host_req/host_wr/host_addr/host_wdata
//   slave : sequencer side      - drives host_ready/host_done/host_err/host_rdata
interface dest_ip_tbl_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              host_req;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_done;
  logic              host_err;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_wr, host_addr, host_wdata,
    input  host_ready, host_done, host_err, host_rdata
  );

  modport slave (
    input  host_req, host_wr, host_addr, host_wdata,
    output host_ready, host_done, host_err, host_rdata
  );

endinterface

// File: rtl/dest_ip_tbl_ctrl.sv
// dest_ip_tbl_ctrl: serialises single host accesses and a bulk clear/fill onto
// the one-shot req/ack port of the destination-IP table, with a per-access ack
// timeout so a lost ack cannot hang the register interface.
// Ports:
//   AXI_ACLK, AXI_RESET      clock, synchronous active-high reset
//   host (slave modport)     host req/ready handshake, done/err/rdata response
//   clr_start, clr_fill      bulk fill request and its fill value
//   clr_busy/done/err        bulk fill status
//   tbl_*                    table request/ack port
//   timeout_count            saturating count of timed-out accesses
module dest_ip_tbl_ctrl #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = dest_ip_tbl_pkg::DATA_W,
  parameter int unsigned TBL_ADDR_W         = dest_ip_tbl_pkg::TBL_ADDR_W,
  parameter int unsigned TIMEOUT            = dest_ip_tbl_pkg::TIMEOUT_DEF
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  dest_ip_tbl_ctrl_if.slave             host,
  input  logic                          clr_start,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] clr_fill,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          clr_err,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_W-1:0]         tbl_rd_addr,
  output logic [TBL_ADDR_W-1:0]         tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack,
  output logic [31:0]                   timeout_count
);

  import dest_ip_tbl_pkg::*;

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned CA_W    = TBL_ADDR_W + 1;
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned LAST_IX = (2 ** TBL_ADDR_W) - 1;

  state_t              state;
  logic                op_wr;
  logic                clr_pending;
  logic [DW-1:0]       clr_fill_q;
  logic [CA_W-1:0]     clr_addr;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                clr_start_ok;
  logic                host_acc;
  logic                wait_expired;
  logic                ack_match;
  logic                last_entry;
  logic [CA_W-1:0]     clr_addr_nxt;
  logic [31:0]         timeout_inc;

  // Clear requests are only taken while no clear is pending or running.
  assign clr_busy     = clr_pending | (state == ST_CLR_ISSUE) | (state == ST_CLR_WAIT);
  assign clr_start_ok = clr_start & ~clr_busy;

  // A same-cycle clr_start blocks the host so the clear wins the IDLE slot.
  assign host.host_ready = ~AXI_RESET & (state == ST_IDLE) & ~clr_pending & ~clr_start;
  assign host_acc        = host.host_req & host.host_ready;

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT));
  assign ack_match    = op_wr ? tbl_wr_ack : tbl_rd_ack;
  assign clr_addr_nxt = clr_addr + CA_W'(1);
  assign last_entry   = (clr_addr == CA_W'(LAST_IX));
  assign timeout_inc  = (timeout_count == 32'hFFFF_FFFF) ? timeout_count
                                                          : timeout_count + 32'd1;

  // Sequencer FSM with registered outputs; req/done/err outputs default low.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state           <= ST_IDLE;
      op_wr           <= 1'b0;
      clr_pending     <= 1'b0;
      clr_fill_q      <= '0;
      clr_addr        <= '0;
      wait_cnt        <= '0;
      tbl_rd_req      <= 1'b0;
      tbl_wr_req      <= 1'b0;
      tbl_rd_addr     <= '0;
      tbl_wr_addr     <= '0;
      tbl_wr_data     <= '0;
      host.host_done  <= 1'b0;
      host.host_err   <= 1'b0;
      host.host_rdata <= '0;
      clr_done        <= 1'b0;
      clr_err         <= 1'b0;
      timeout_count   <= '0;
    end else begin
      tbl_rd_req     <= 1'b0;
      tbl_wr_req     <= 1'b0;
      host.host_done <= 1'b0;
      host.host_err  <= 1'b0;
      clr_done       <= 1'b0;
      clr_err        <= 1'b0;

      // Outside IDLE a clear request is parked until the FSM returns.
      if (clr_start_ok && (state != ST_IDLE)) begin
        clr_pending <= 1'b1;
        clr_fill_q  <= clr_fill;
      end

      unique case (state)
        ST_IDLE: begin
          if (clr_pending || clr_start_ok) begin
            clr_pending <= 1'b0;
            clr_addr    <= '0;
            tbl_wr_addr <= '0;
            tbl_wr_data <= clr_pending ? clr_fill_q : clr_fill;
            tbl_wr_req  <= 1'b1;
            state       <= ST_CLR_ISSUE;
          end else if (host_acc) begin
            op_wr <= host.host_wr;
            if (host.host_wr) begin
              tbl_wr_req  <= 1'b1;
              tbl_wr_addr <= host.host_addr;
              tbl_wr_data <= host.host_wdata;
            end else begin
              tbl_rd_req  <= 1'b1;
              tbl_rd_addr <= host.host_addr;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (ack_match) begin
            if (!op_wr) host.host_rdata <= tbl_rd_data;
            host.host_done <= 1'b1;
            state          <= ST_DONE;
          end else if (wait_expired) begin
            host.host_done <= 1'b1;
            host.host_err  <= 1'b1;
            timeout_count  <= timeout_inc;
            state          <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        ST_CLR_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_CLR_WAIT;
        end

        ST_CLR_WAIT: begin
          if (tbl_wr_ack) begin
            if (last_entry) begin
              clr_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              clr_addr    <= clr_addr_nxt;
              tbl_wr_addr <= TBL_ADDR_W'(clr_addr_nxt);
              tbl_wr_req  <= 1'b1;
              state       <= ST_CLR_ISSUE;
            end
          end else if (wait_expired) begin
            clr_done      <= 1'b1;
            clr_err       <= 1'b1;
            timeout_count <= timeout_inc;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dest_ip_tbl_ctrl.md
# dest_ip_tbl_ctrl

Sequencer and arbiter for the 32-entry destination-IP table in the router output-port-lookup core. Serialises single host read/write requests from the register block and a bulk clear/fill engine onto the table's one-shot req/ack port. Enforces a per-access ack timeout so a missing ack cannot hang the register interface. Sits between the AXI-lite register decode and the dest_ip table port.

## Interface
- C_S_AXI_DATA_WIDTH, 32: table entry / data width
- TBL_ADDR_W, 5: table address width (depth 2^TBL_ADDR_W = 32)
- TIMEOUT, 16: cycles to wait for an ack before abort (≥2)

- AXI_ACLK  in  1  sole clock, all logic on rising edge
- AXI_RESET  in  1  synchronous, active-high reset
- host_req  in  1  host access valid; held until accepted
- host_wr  in  1  1 = write, 0 = read; qualified by host_req
- host_addr  in  TBL_ADDR_W  host entry index
- host_wdata  in  DATA_W  host write value
- host_ready  out  1  host_req accepted when host_req & host_ready
- host_done  out  1  one-cycle pulse, access finished
- host_err  out  1  valid with host_done; 1 = timed out
- host_rdata  out  DATA_W  read result; held from host_done until next read completes
- clr_start  in  1  one-cycle pulse, fill whole table
- clr_fill  in  DATA_W  fill value, sampled on clr_start acceptance
- clr_busy  out  1  clear pending or running
- clr_done  out  1  one-cycle pulse at clear end
- clr_err  out  1  valid with clr_done; 1 = aborted by timeout
- tbl_rd_req / tbl_wr_req  out  1  one-cycle request to table
- tbl_rd_addr / tbl_wr_addr  out  TBL_ADDR_W  table addresses
- tbl_wr_data  out  DATA_W  table write data
- tbl_rd_data  in  DATA_W  table read data, valid with tbl_rd_ack
- tbl_rd_ack / tbl_wr_ack  in  1  table acks
- timeout_count  out  32  total timeouts since reset, saturating

## Operation
- States: IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT, DONE.
- IDLE: clr_pending has priority over host. host_ready = (state==IDLE) & !clr_pending & !clr_start.
- Host accept → latch wr/addr/wdata → ISSUE: drive exactly one matching tbl_*_req cycle → WAIT.
- WAIT: matching ack → capture tbl_rd_data (read) → DONE, host_err=0. Wait counter reaching TIMEOUT → DONE, host_err=1, timeout_count+1, host_rdata unchanged.
- DONE: host_done pulse one cycle → IDLE.
- clr_start in any state sets clr_pending and latches clr_fill; ignored (no latch, no effect) while clr_busy already 1. clr_busy = clr_pending | clear running.
- Clear: IDLE with clr_pending → addr=0 → CLR_ISSUE (tbl_wr_req, data=fill) → CLR_WAIT; on wr ack increment addr; after addr 31 acked → clr_done, clr_err=0 → IDLE. Timeout in CLR_WAIT: abort, clr_done, clr_err=1, timeout_count+1, → IDLE.
- Only the ack matching the outstanding request type is accepted; acks in any other state or of the other type are ignored.
- Address counter is TBL_ADDR_W+1 bits; termination on wrapped index 31, no wrap to 0.
- timeout_count saturates at 0xFFFFFFFF.

## Timing
- Reset values: all outputs 0, host_rdata 0, timeout_count 0, state IDLE, clr_pending 0. Reset mid-access abandons it: no done pulse, table req dropped next cycle.
- Host accept at edge k → tbl req high cycle k+1 → table ack cycle k+2 → host_done cycle k+3. Total 3 cycles, no back-to-back overlap; next host_ready in cycle k+4.
- Clear of 32 entries with 1-cycle ack: 2 cycles/entry, clr_done 65 cycles after clr_start.
- Timeout: host_done/clr_done exactly TIMEOUT+2 cycles after request cycle.
- clr_start and host_req in same IDLE cycle: host not accepted, clear runs first.
- tbl_*_req never both high; never high outside ISSUE/CLR_ISSUE.

## Structure
- Package dest_ip_tbl_pkg: state encoding constants, TBL_DEPTH=32, TBL_ADDR_W, default TIMEOUT.
- Single module; no sub-module. Wait counter shared between host and clear paths.

## Test plan
- Host write addr 5, data 0x0A000001; ack next cycle → tbl_wr_req 1 cycle with addr 5, host_done 3 cycles after accept, host_err 0.
- Host read addr 5, tbl_rd_data 0x0A000001 → host_rdata 0x0A000001 at host_done.
- clr_start with fill 0 → 32 writes to addrs 0..31, clr_done at cycle 65, clr_err 0; host_req during clear waits, is accepted the cycle after clr_done.
- Ack suppressed on host read → host_done with host_err 1 at TIMEOUT+2, timeout_count 1; late ack afterwards ignored.
- Host write in WAIT + clr_start pulse → write completes first, clear starts next IDLE cycle; second clr_start while busy ignored.
- AXI_RESET asserted in CLR_WAIT at addr 10 → no clr_done, all outputs 0 next cycle, IDLE.
